// File: rtl/systolic_output_drain.sv
// systolic_output_drain: reads the finished HIDDEN_SIZE x CONTEXT_LENGTH result
// matrix of the systolic array one row at a time, latches each row locally and
// streams it out as LANES-wide valid/ready beats.
// Optional feature macro: DRAIN_SATURATE_EN (clamp every element to the signed
// WIDTH range and sign-extend it back to 2*WIDTH bits while the row is latched).
module systolic_output_drain #(
  parameter int WIDTH          = 16,
  parameter int HIDDEN_SIZE    = 64,
  parameter int CONTEXT_LENGTH = 128,
  parameter int LANES          = 8
) (
  input  logic                                       clock,
  input  logic                                       rst,
  input  logic                                       start,
  output logic [$clog2(HIDDEN_SIZE)-1:0]             row_addr,
  input  logic signed [CONTEXT_LENGTH*2*WIDTH-1:0]   row_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic signed [LANES*2*WIDTH-1:0]            out_data,
  output logic [$clog2(HIDDEN_SIZE)-1:0]             out_row,
  output logic                                       out_row_last,
  output logic                                       out_last,
  output logic                                       busy,
  output logic                                       done
);

  localparam int EW    = 2 * WIDTH;
  localparam int SLICE = LANES * EW;
  localparam int ROW_W = CONTEXT_LENGTH * EW;
  localparam int BEATS = CONTEXT_LENGTH / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = $clog2(HIDDEN_SIZE);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(HIDDEN_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Per-element conditioning applied as a row is latched into the local buffer.
  function automatic logic [EW-1:0] sat_elem(input logic [EW-1:0] v);
`ifdef DRAIN_SATURATE_EN
    // In range exactly when all bits from the WIDTH sign bit upward agree.
    if ((v[EW-1:WIDTH-1] == '0) || (v[EW-1:WIDTH-1] == '1)) begin
      return v;
    end else if (v[EW-1] == 1'b0) begin
      return {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    end else begin
      return {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};
    end
`else
    return v;
`endif
  endfunction

  // Condition a whole row element by element.
  function automatic logic [ROW_W-1:0] load_row(input logic [ROW_W-1:0] d);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < CONTEXT_LENGTH; c++) begin
      r[c*EW +: EW] = sat_elem(d[c*EW +: EW]);
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [ROW_W-1:0]   row_buf_q, row_buf_d;
  logic               out_valid_q, out_valid_d;
  logic [SLICE-1:0]   out_data_q, out_data_d;
  logic               out_row_last_q, out_row_last_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [ROW_W-1:0]   loaded;
  logic [BW-1:0]      next_beat;
  logic               fire;

  assign loaded    = load_row(row_data);
  assign next_beat = beat_q + BW'(1);
  assign fire      = out_valid_q && out_ready;

  // Next-state and next-output computation; every output is registered so the
  // beat presented in STREAM is prepared one edge ahead.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    beat_d         = beat_q;
    row_buf_d      = row_buf_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_row_last_d = out_row_last_q;
    out_last_d     = out_last_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          row_d   = '0;
          beat_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // row_addr (= row_q) selects the row; it is latched at this edge and
        // its first beat is presented straight away.
        row_buf_d      = loaded;
        beat_d         = '0;
        out_valid_d    = 1'b1;
        out_data_d     = loaded[SLICE-1:0];
        out_row_last_d = (BEATS == 1);
        out_last_d     = (BEATS == 1) && (row_q == LAST_ROW);
        state_d        = S_STREAM;
      end
      S_STREAM: begin
        if (fire) begin
          if (beat_q != LAST_BEAT) begin
            beat_d         = next_beat;
            out_data_d     = row_buf_q[int'(next_beat)*SLICE +: SLICE];
            out_row_last_d = (next_beat == LAST_BEAT);
            out_last_d     = (next_beat == LAST_BEAT) && (row_q == LAST_ROW);
          end else if (row_q != LAST_ROW) begin
            row_d          = row_q + RW'(1);
            out_valid_d    = 1'b0;
            out_row_last_d = 1'b0;
            out_last_d     = 1'b0;
            state_d        = S_LOAD;
          end else begin
            out_valid_d    = 1'b0;
            out_row_last_d = 1'b0;
            out_last_d     = 1'b0;
            done_d         = 1'b1;
            state_d        = S_DONE;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        out_valid_d    = 1'b0;
        out_row_last_d = 1'b0;
        out_last_d     = 1'b0;
        busy_d         = 1'b0;
        state_d        = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset that abandons any transfer.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q        <= S_IDLE;
      row_q          <= '0;
      beat_q         <= '0;
      row_buf_q      <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_row_last_q <= 1'b0;
      out_last_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      beat_q         <= beat_d;
      row_buf_q      <= row_buf_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_row_last_q <= out_row_last_d;
      out_last_q     <= out_last_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // row_q only changes on the way into LOAD, so it doubles as the held row select.
  assign row_addr     = row_q;
  assign out_row      = row_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_row_last = out_row_last_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_systolic_output_drain.sv
// Self-checking bench for systolic_output_drain (WIDTH=16, HIDDEN_SIZE=4,
// CONTEXT_LENGTH=8, LANES=4). Expected beats, timing and payloads come from a
// matrix-level reference model; build with DRAIN_SATURATE_EN to check clamping.
module tb_systolic_output_drain;

  localparam int WIDTH = 16;
  localparam int HS    = 4;
  localparam int CL    = 8;
  localparam int LN    = 4;
  localparam int BEATS = CL / LN;
  localparam int EW    = 2 * WIDTH;

  logic                    clock = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [1:0]              row_addr;
  logic signed [CL*EW-1:0] row_data;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [LN*EW-1:0] out_data;
  logic [1:0]              out_row;
  logic                    out_row_last;
  logic                    out_last;
  logic                    busy;
  logic                    done;

  logic signed [EW-1:0]    mat [HS][CL];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           row;
    int           beat;
    logic [127:0] data;
    logic         rl;
    logic         last;
  } beat_t;

  beat_t exp_q[$];

  systolic_output_drain #(
    .WIDTH(WIDTH), .HIDDEN_SIZE(HS), .CONTEXT_LENGTH(CL), .LANES(LN)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .row_addr(row_addr),
    .row_data(row_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_row_last(out_row_last),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // The array model: the selected accumulator row, combinationally.
  always_comb begin
    row_data = '0;
    for (int c = 0; c < CL; c++) row_data[c*EW +: EW] = mat[row_addr][c];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] model_elem(input logic signed [EW-1:0] v);
`ifdef DRAIN_SATURATE_EN
    if (v > 32767) return 32'sd32767;
    else if (v < -32768) return -32'sd32768;
    else return v;
`else
    return v;
`endif
  endfunction

  task automatic fill_default();
    for (int r = 0; r < HS; r++)
      for (int c = 0; c < CL; c++) mat[r][c] = EW'(r * 100 + c - 3);
  endtask

  task automatic build_expect();
    beat_t e;
    exp_q.delete();
    for (int r = 0; r < HS; r++) begin
      for (int b = 0; b < BEATS; b++) begin
        e.row  = r;
        e.beat = b;
        e.data = '0;
        for (int k = 0; k < LN; k++) e.data[k*EW +: EW] = model_elem(mat[r][b*LN+k]);
        e.rl   = (b == BEATS - 1);
        e.last = (b == BEATS - 1) && (r == HS - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // One start-to-done transfer. start2/rst_cyc < 0 disable the extra start/reset.
  task automatic drain(input int ready_pct, input int start2, input int rst_cyc);
    int           stalls = 0;
    int           done_cyc = -1;
    int           ndone = 0;
    bit           prev_stall = 1'b0;
    logic [127:0] p_data = '0;
    logic [1:0]   p_row = '0;
    logic         p_rl = 1'b0;
    logic         p_last = 1'b0;
    beat_t        e;
    build_expect();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      start     = (cyc == 0) || (cyc == start2);
      rst       = (cyc == rst_cyc);
      out_ready = ($urandom_range(99) < ready_pct);
      if (cyc == 0) begin
        check("idle_busy", busy, 1'b0);
        check("idle_valid", out_valid, 1'b0);
      end
      if (cyc == 1) begin
        check("load_busy", busy, 1'b1);
        check("load_valid", out_valid, 1'b0);
        check("load_row_addr", row_addr, 2'd0);
      end
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_row_last", out_row_last, 1'b0);
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clock);
          check("rst_quiet_done", done, 1'b0);
          check("rst_quiet_valid", out_valid, 1'b0);
        end
        return;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          if (prev_stall) begin
            check("stall_data", out_data, p_data);
            check("stall_row", out_row, p_row);
            check("stall_row_last", out_row_last, p_rl);
            check("stall_last", out_last, p_last);
          end else begin
            check("beat_cycle", cyc, 2 + e.row * (BEATS + 1) + e.beat + stalls);
          end
          check("beat_data", out_data, e.data);
          check("beat_row", out_row, e.row);
          check("beat_row_last", out_row_last, e.rl);
          check("beat_last", out_last, e.last);
          p_data = out_data; p_row = out_row; p_rl = out_row_last; p_last = out_last;
          if (out_ready) begin
            void'(exp_q.pop_front());
            prev_stall = 1'b0;
          end else begin
            stalls++;
            prev_stall = 1'b1;
          end
        end
      end else begin
        if (prev_stall) check("stall_dropped_valid", out_valid, 1'b1);
        prev_stall = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("done_cycle", cyc, 1 + HS * (BEATS + 1) + stalls);
          done_cyc = cyc;
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) check("busy_after_done", busy, 1'b0);
      if (done_cyc >= 0 && cyc == done_cyc + 4) break;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("done_count", ndone, 1);
    check("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    fill_default();
    // Reset values.
    rst = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", out_data, 128'd0);
    check("reset_row", out_row, 2'd0);
    check("reset_row_last", out_row_last, 1'b0);
    check("reset_last", out_last, 1'b0);
    check("reset_row_addr", row_addr, 2'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);

    // Full drain with out_ready held high.
    drain(100, -1, -1);
    // Random backpressure, same matrix.
    drain(60, -1, -1);
    // start while busy, and start coinciding with the done cycle.
    drain(100, 5, -1);
    drain(100, 1 + HS * (BEATS + 1), -1);
    // Reset mid-stream, then a fresh drain from row 0.
    drain(100, -1, 6);
    drain(100, -1, -1);
    // Signed extremes.
    mat[2][5] = 32'sh7FFF_FFFF;
    mat[3][0] = 32'sh8000_0000;
    drain(100, -1, -1);
    drain(50, -1, -1);
    // Random matrix under random backpressure.
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < HS; r++)
        for (int c = 0; c < CL; c++) mat[r][c] = $urandom;
      drain(70, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_output_drain.md
# systolic_output_drain

Result-side reader for the ternary-weight systolic array. After the array finishes accumulating a HIDDEN_SIZE × CONTEXT_LENGTH output matrix, the drain reads it one row at a time through a row-select port. It latches each row into a local buffer and streams it out as LANES-wide beats on a valid/ready interface toward the output buffer or host DMA. It is the consumer counterpart of the X/W column feed that loads the array.

## Interface

Parameters:
- WIDTH, 16, activation width; result elements are 2*WIDTH bits signed.
- HIDDEN_SIZE, 64, number of result rows (one per weight column).
- CONTEXT_LENGTH, 128, number of elements per row; must be a multiple of LANES.
- LANES, 8, elements per output beat.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the controller: the array result is final.
- row_addr  out  $clog2(HIDDEN_SIZE)  row select driven to the array.
- row_data  in  CONTEXT_LENGTH×2*WIDTH, signed packed  row of the array accumulators selected by row_addr; combinational, valid in the same cycle.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES×2*WIDTH, signed packed  beat payload; lane k = element beat*LANES+k, lane 0 in the LSBs.
- out_row  out  $clog2(HIDDEN_SIZE)  row index of the current beat.
- out_row_last  out  1  final beat of the current row.
- out_last  out  1  final beat of the whole matrix.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final beat is accepted.

## Operation

States: IDLE, LOAD, STREAM, DONE.

- **IDLE**
  - start=1 → LOAD; row counter=0; beat counter=0.
  - start is ignored in every other state.
- **LOAD** (one cycle)
  - row_addr = row counter.
  - row_buf ← row_data.
  - beat counter=0.
  - → STREAM.
- **STREAM**
  - out_valid=1.
  - out_data = row_buf slice [beat*LANES +: LANES].
  - On out_valid && out_ready:
    - Not the final beat of the row: beat++.
    - Final beat, not the final row: row++ and → LOAD.
    - Final beat of the final row: → DONE.
- **DONE**
  - done=1 for one cycle.
  - → IDLE.
- Rules:
  - BEATS = CONTEXT_LENGTH/LANES.
  - out_row_last = (beat == BEATS-1).
  - out_last = out_row_last && (row == HIDDEN_SIZE-1).
  - out_valid never depends on out_ready.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - Data is passed through unmodified unless the Configuration macro is defined.
  - row_addr holds its last value outside LOAD.

## Timing

- Reset values: out_valid=0, out_data=0, out_row=0, out_row_last=0, out_last=0, row_addr=0, busy=0, done=0, state=IDLE.
- Latency: start in cycle 0 → LOAD in cycle 1 → first out_valid in cycle 2.
- One LOAD bubble per row: out_valid=0 for exactly one cycle between rows.
- Throughput with out_ready held high: HIDDEN_SIZE*(BEATS+1) cycles from the first LOAD to the last beat. done follows in the next cycle.
- Backpressure: a stall of n cycles delays every later event by exactly n.
- rst asserted in any state:
  - Next cycle is IDLE with reset values.
  - The partial transfer is abandoned and no done pulse is issued.
- start coinciding with the done cycle is ignored.
- Degenerate size LANES == CONTEXT_LENGTH: every beat has out_row_last=1.

## Configuration

- DRAIN_SATURATE_EN
  - Defined: each element is saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1], then sign-extended back to 2*WIDTH bits in out_data.
  - Saturation is applied in LOAD when row_buf is written, so it adds no cycles.
  - Undefined: full 2*WIDTH results are passed through unchanged.

## Test plan

Parameters for all scenarios: WIDTH=16, HIDDEN_SIZE=4, CONTEXT_LENGTH=8, LANES=4. Element (r,c) = r*100+c-3 unless stated.

1. **Full drain, out_ready=1.**
   - Start pulse → 8 beats in cycles 2-3, 5-6, 8-9, 11-12.
   - Beat 0 lanes = -3, -2, -1, 0; out_last on the beat in cycle 12.
   - done in cycle 13; busy low in cycle 14.
2. **Random backpressure.**
   - out_ready toggles pseudo-randomly.
   - Payload stays stable during every stall.
   - Beat sequence is identical to scenario 1; total cycles = 13 + number of stall cycles.
3. **start while busy.**
   - Second start pulse in cycle 5.
   - Ignored: exactly 8 beats and one done pulse.
4. **Reset mid-stream.**
   - rst=1 in cycle 6 for one cycle.
   - Next cycle: out_valid=0, busy=0, no done.
   - A fresh start then drains from row 0.
5. **Signed extremes.**
   - Element (2,5) = 0x7FFF_FFFF and element (3,0) = 0x8000_0000.
   - Without DRAIN_SATURATE_EN: emitted unchanged.
   - With DRAIN_SATURATE_EN: emitted as 0x0000_7FFF and 0xFFFF_8000; -3 is emitted as 0xFFFF_FFFD.
